multiword_alu_seq: RTL
======================

// Module: multiword_alu_seq
// PURPOSE
//  Sequencer that runs one wide (N*WORDS-bit) arithmetic/logic operation through a single N-bit alu.
//  Processes one word per cycle, LSW first, chaining carry between words.
//  Produces a wide result and NZCV flags consistent with the single-word alu.
//  Sits beside the execute stage; serves multi-precision ops (e.g. 128-bit add) without widening the datapath.
// PARAMETERS
//  N      32  alu word width, bits
//  WORDS  4   words per operation (>=1); operand width W = N*WORDS
// PORTS
//  clk         in   1    single clock; all state updates on rising edge
//  rst         in   1    synchronous, active-high reset
//  start       in   1    request; accepted only when busy=0
//  command     in   4    alu opcode (MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000)
//  operand_a   in   W    wide operand A, sampled with start
//  operand_b   in   W    wide operand B, sampled with start
//  carry_in    in   1    C input for ADC/SBC, sampled with start
//  busy        out  1    high from cycle after accept until done cycle inclusive
//  done        out  1    one-cycle pulse; result/status_out valid
//  result      out  W    wide result; holds until next done
//  status_out  out  4    {N,Z,C,V}; holds until next done
// BEHAVIOUR
//  Reset: state IDLE, busy=0, done=0, result=0, status_out=0, word index=0. Reset mid-operation aborts; no done pulse.
//  FSM: IDLE --start--> RUN (WORDS cycles, index 0..WORDS-1) --> DONE (1 cycle) --> IDLE.
//  Timing: start high in cycle 0 -> RUN cycles 1..WORDS -> done=1 in cycle WORDS+1 -> start accepted again from cycle WORDS+2.
//  start while busy=1 ignored (no queueing); operands and command latched at accept only.
//  Per RUN cycle: alu gets a=A[i], b=B[i]; its result is written to result-shadow word i; result/status_out update only on entering DONE.
//  Word 0 uses the latched command and carry_in. Words 1.. use an opcode mapped by class:
//   add-class (ADD/ADC): ADC, carry = alu C of previous word.
//   sub-class (SUB/SBC): SBC, carry = ~(alu C of previous word); alu C is a borrow bit.
//   logic/move (MOV/MVN/AND/ORR/EOR): same opcode every word; carry unused.
//   undefined opcode: alu gives 0 every word.
//  Flags: N = MSW result bit N-1; Z = 1 iff all WORDS words zero; C, V = alu C, V of MSW (0 for logic/move/undefined).
//  WORDS=1 is identical to one alu operation registered with 2-cycle latency.
//  Widths: word select is a $clog2(WORDS)-bit counter (min 1 bit); no wrap past WORDS-1 (RUN exits at index WORDS-1).
// STRUCTURE
//  Shared header alu_defs.vh: 4-bit opcode localparams (CMD_MOV..CMD_EOR), class decode function, state encodings.
//  One sub-module: the existing N-bit alu, instantiated once.
//  Local logic: FSM, word counter, operand/command/carry latches, result shadow, zero-accumulator.
// TESTING (N=32, WORDS=4)
//  ADD A=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, B=1 -> done in cycle 5, result=0x0000_0000_0000_0001_0000_0000_0000_0000, NZCV=0000.
//  SUB A=0, B=1 -> result=all-F (128b), NZCV=1010 (C=raw borrow 1, V=0).
//  ADD A=0x7FFF..FF, B=1 -> result=0x8000..00, NZCV=1001.
//  ADC A=all-F, B=0, carry_in=1 -> result=0, NZCV=0110; EOR A=B=0x1234.. -> result=0, NZCV=0100.
//  start pulsed in cycles 0 and 2 -> one done only (cycle 5); second start ignored, busy=1 in cycles 1..5.
//  rst high in cycle 2 of an ADD -> cycle 3: busy=0, result=0, status_out=0; no done pulse; next start runs normally.

Source files
------------

// File: rtl/multiword_alu_seq_pkg.sv
// Shared definitions for the multi-word ALU sequencer: opcodes, opcode classes and FSM states.
package multiword_alu_seq_pkg;

    localparam logic [3:0] CmdMov = 4'b0001;
    localparam logic [3:0] CmdMvn = 4'b1001;
    localparam logic [3:0] CmdAdd = 4'b0010;
    localparam logic [3:0] CmdAdc = 4'b0011;
    localparam logic [3:0] CmdSub = 4'b0100;
    localparam logic [3:0] CmdSbc = 4'b0101;
    localparam logic [3:0] CmdAnd = 4'b0110;
    localparam logic [3:0] CmdOrr = 4'b0111;
    localparam logic [3:0] CmdEor = 4'b1000;

    typedef enum logic [1:0] {ClsAdd, ClsSub, ClsLogic, ClsUndef} cmd_class_e;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    function automatic cmd_class_e cmd_class(input logic [3:0] cmd);
        cmd_class_e cls;
        case (cmd)
            CmdAdd, CmdAdc:                         cls = ClsAdd;
            CmdSub, CmdSbc:                         cls = ClsSub;
            CmdMov, CmdMvn, CmdAnd, CmdOrr, CmdEor: cls = ClsLogic;
            default:                                cls = ClsUndef;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multiword_alu_seq_alu.sv
// Single-word N-bit ALU producing {N,Z,C,V}; for subtracts C is a borrow bit.
module multiword_alu_seq_alu
    import multiword_alu_seq_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [3:0]   command_i,
    input  logic         carry_i,
    output logic [N-1:0] result_o,
    output logic [3:0]   status_o
);

    logic [N:0]   wide;
    logic [N-1:0] res;
    logic         c;
    logic         v;
    logic         add_cin;
    logic         sub_borrow;

    // SBC subtracts an extra 1 when carry is clear (carry acts as "not borrow").
    assign add_cin    = (command_i == CmdAdc) ? carry_i : 1'b0;
    assign sub_borrow = (command_i == CmdSbc) ? ~carry_i : 1'b0;

    always_comb begin
        wide = '0;
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (command_i)
            CmdMov: res = b_i;
            CmdMvn: res = ~b_i;
            CmdAnd: res = a_i & b_i;
            CmdOrr: res = a_i | b_i;
            CmdEor: res = a_i ^ b_i;
            CmdAdd, CmdAdc: begin
                wide = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, add_cin};
                res  = wide[N-1:0];
                c    = wide[N];
                v    = (a_i[N-1] == b_i[N-1]) && (res[N-1] != a_i[N-1]);
            end
            CmdSub, CmdSbc: begin
                wide = {1'b0, a_i} - {1'b0, b_i} - {{N{1'b0}}, sub_borrow};
                res  = wide[N-1:0];
                c    = wide[N];
                v    = (a_i[N-1] != b_i[N-1]) && (res[N-1] != a_i[N-1]);
            end
            default: res = '0;
        endcase
    end

    assign result_o = res;
    assign status_o = {res[N-1], (res == '0), c, v};

endmodule

// File: rtl/multiword_alu_seq.sv
// Runs one WORDS*N-bit operation through a single N-bit ALU, one word per cycle, LSW first,
// chaining carry/borrow between words and producing a wide result with NZCV flags.
module multiword_alu_seq
    import multiword_alu_seq_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           command,
    input  logic [N*WORDS-1:0]   operand_a,
    input  logic [N*WORDS-1:0]   operand_b,
    input  logic                 carry_in,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   result,
    output logic [3:0]           status_out
);

    localparam int unsigned W    = N * WORDS;
    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    state_e                    state_q;
    logic [IdxW-1:0]           idx_q;
    logic [WORDS-1:0][N-1:0]   a_q;
    logic [WORDS-1:0][N-1:0]   b_q;
    logic [WORDS-1:0][N-1:0]   shadow_q;
    logic [WORDS-1:0][N-1:0]   shadow_d;
    logic [3:0]                cmd_q;
    logic                      cin_q;
    logic                      prev_c_q;
    logic                      zero_q;
    logic [W-1:0]              result_q;
    logic [3:0]                status_q;
    logic                      busy_q;
    logic                      done_q;

    logic [3:0]   alu_cmd;
    logic         alu_cin;
    logic [N-1:0] alu_res;
    logic [3:0]   alu_status;

    // Upper words continue the operation: add-class chains carry, sub-class chains borrow.
    always_comb begin
        alu_cmd = cmd_q;
        alu_cin = cin_q;
        if (idx_q != '0) begin
            case (cmd_class(cmd_q))
                ClsAdd: begin
                    alu_cmd = CmdAdc;
                    alu_cin = prev_c_q;
                end
                ClsSub: begin
                    alu_cmd = CmdSbc;
                    alu_cin = ~prev_c_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        shadow_d        = shadow_q;
        shadow_d[idx_q] = alu_res;
    end

    multiword_alu_seq_alu #(
        .N(N)
    ) u_alu (
        .a_i       (a_q[idx_q]),
        .b_i       (b_q[idx_q]),
        .command_i (alu_cmd),
        .carry_i   (alu_cin),
        .result_o  (alu_res),
        .status_o  (alu_status)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            cmd_q    <= '0;
            cin_q    <= 1'b0;
            prev_c_q <= 1'b0;
            zero_q   <= 1'b1;
            result_q <= '0;
            status_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= operand_a;
                        b_q     <= operand_b;
                        cmd_q   <= command;
                        cin_q   <= carry_in;
                        idx_q   <= '0;
                        zero_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    shadow_q <= shadow_d;
                    prev_c_q <= alu_status[1];
                    zero_q   <= zero_q & alu_status[2];
                    if (idx_q == LastIdx) begin
                        result_q <= shadow_d;
                        status_q <= {alu_status[3], zero_q & alu_status[2], alu_status[1:0]};
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign status_out = status_q;

endmodule
